mmc1_bus_responder: RTL and testbench

Cartridge-side responder for the Famicom CPU/PPU bus: the MMC1-compatible mapper that the dumper's bus cycles talk to. It samples M2, /ROMSEL, R/W, address and data on `master_clock`, decodes serial writes to $8000–$FFFF into the four MMC1 registers, and drives PRG/CHR bank address lines, CIRAM A10 and PRG-RAM chip enable. It sits in the cartridge test fixture, opposite the dumper CPLD, and serves as a loopback target when validating dumper write timing.

---
 rtl/mmc1_bus_responder.sv | 150 +++++++++++++++
 tb/tb_mmc1_bus_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mmc1_bus_responder.sv
// MMC1-compatible cartridge-side bus responder: synchronizes the Famicom CPU bus,
// decodes the serial register protocol and drives PRG/CHR banking and mirroring.
`timescale 1ns/1ps
module mmc1_bus_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       master_clock,
   input  logic       reset,
   input  logic       m2,
   input  logic       romsel,
   input  logic       cpu_rw,
   input  logic [1:0] cpu_a,
   input  logic [1:0] cpu_d,
   input  logic [2:0] ppu_a,
   output logic [3:0] prg_a,
   output logic [4:0] chr_a,
   output logic       ciram_a10,
   output logic       prg_ram_ce_n,
   output logic       reg_write,
   output logic [1:0] reg_index
);

   // Packed bus word: {m2, romsel, rw, a14, a13, d7, d0}; idle has romsel/rw high.
   localparam logic [6:0] BUS_IDLE   = 7'b0110000;
   localparam logic [4:0] SHIFT_INIT = 5'b10000;

   logic [6:0] bus_raw;
   logic [6:0] sync_reg [SYNC_STAGES];
   logic [6:0] bus_sync;
   logic       m2_sync;

   logic       m2_prev_reg;
   logic [5:0] cap_reg, cap_next;
   logic [4:0] shift_reg, shift_next;
   logic [4:0] control_reg, control_next;
   logic [4:0] chr0_reg, chr0_next;
   logic [4:0] chr1_reg, chr1_next;
   logic [4:0] prg_reg, prg_next;
   logic       prev_write_reg, prev_write_next;
   logic       reg_write_reg, reg_write_next;
   logic [1:0] reg_index_reg, reg_index_next;

   logic       cycle_end;
   logic       rom_write;
   logic [4:0] commit_val;

   assign bus_raw  = {m2, romsel, cpu_rw, cpu_a, cpu_d};
   assign bus_sync = sync_reg[SYNC_STAGES-1];
   assign m2_sync  = bus_sync[6];

   always_ff @(posedge master_clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= BUS_IDLE;
      end else begin
         sync_reg[0] <= bus_raw;
         for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      end
   end

   assign cycle_end = !m2_sync && m2_prev_reg;
   assign rom_write = cycle_end && !cap_reg[5] && !cap_reg[4];

   always_comb begin
      cap_next        = m2_sync ? bus_sync[5:0] : cap_reg;
      shift_next      = shift_reg;
      control_next    = control_reg;
      chr0_next       = chr0_reg;
      chr1_next       = chr1_reg;
      prg_next        = prg_reg;
      prev_write_next = prev_write_reg;
      reg_write_next  = 1'b0;
      reg_index_next  = reg_index_reg;
      commit_val      = {cap_reg[0], shift_reg[4:1]};

      if (cycle_end) prev_write_next = rom_write;

      if (rom_write) begin
         if (cap_reg[1]) begin
            shift_next   = SHIFT_INIT;
            control_next = control_reg | 5'b01100;
         end else if (!prev_write_reg) begin
            // Marker bit reaching bit 0 means this is the fifth serial bit.
            if (shift_reg[0]) begin
               shift_next     = SHIFT_INIT;
               reg_write_next = 1'b1;
               reg_index_next = cap_reg[3:2];
               case (cap_reg[3:2])
                  2'd0:    control_next = commit_val;
                  2'd1:    chr0_next    = commit_val;
                  2'd2:    chr1_next    = commit_val;
                  default: prg_next     = commit_val;
               endcase
            end else begin
               shift_next = {cap_reg[0], shift_reg[4:1]};
            end
         end
      end
   end

   always_ff @(posedge master_clock) begin
      if (reset) begin
         m2_prev_reg    <= 1'b0;
         cap_reg        <= BUS_IDLE[5:0];
         shift_reg      <= SHIFT_INIT;
         control_reg    <= 5'h0C;
         chr0_reg       <= 5'd0;
         chr1_reg       <= 5'd0;
         prg_reg        <= 5'd0;
         prev_write_reg <= 1'b0;
         reg_write_reg  <= 1'b0;
         reg_index_reg  <= 2'd0;
      end else begin
         m2_prev_reg    <= m2_sync;
         cap_reg        <= cap_next;
         shift_reg      <= shift_next;
         control_reg    <= control_next;
         chr0_reg       <= chr0_next;
         chr1_reg       <= chr1_next;
         prg_reg        <= prg_next;
         prev_write_reg <= prev_write_next;
         reg_write_reg  <= reg_write_next;
         reg_index_reg  <= reg_index_next;
      end
   end

   assign reg_write = reg_write_reg;
   assign reg_index = reg_index_reg;

   // Banking outputs use raw address pins so they follow the bus without sync delay.
   always_comb begin
      case (control_reg[3:2])
         2'd2:    prg_a = cpu_a[1] ? prg_reg[3:0] : 4'h0;
         2'd3:    prg_a = cpu_a[1] ? 4'hF : prg_reg[3:0];
         default: prg_a = {prg_reg[3:1], cpu_a[1]};
      endcase

      if (control_reg[4]) chr_a = ppu_a[2] ? chr1_reg : chr0_reg;
      else                chr_a = {chr0_reg[4:1], ppu_a[2]};

      case (control_reg[1:0])
         2'd0:    ciram_a10 = 1'b0;
         2'd1:    ciram_a10 = 1'b1;
         2'd2:    ciram_a10 = ppu_a[0];
         default: ciram_a10 = ppu_a[1];
      endcase
   end

   assign prg_ram_ce_n = !(m2 && romsel && (cpu_a == 2'b11) && !prg_reg[4]);

endmodule

// File: tb/tb_mmc1_bus_responder.sv
// Directed bench for mmc1_bus_responder: drives serial MMC1 register writes over
// a modelled CPU bus and checks banking outputs and commit pulses.
`timescale 1ns/1ps
module tb_mmc1_bus_responder;

   logic       master_clock = 1'b0;
   logic       reset;
   logic       m2;
   logic       romsel;
   logic       cpu_rw;
   logic [1:0] cpu_a;
   logic [1:0] cpu_d;
   logic [2:0] ppu_a;
   logic [3:0] prg_a;
   logic [4:0] chr_a;
   logic       ciram_a10;
   logic       prg_ram_ce_n;
   logic       reg_write;
   logic [1:0] reg_index;

   int n_checks = 0;
   int n_bad    = 0;
   int wr_count = 0;
   int base;
   logic [1:0] last_idx = 2'd0;

   mmc1_bus_responder #(.SYNC_STAGES(2)) dut (
      .master_clock(master_clock),
      .reset(reset),
      .m2(m2),
      .romsel(romsel),
      .cpu_rw(cpu_rw),
      .cpu_a(cpu_a),
      .cpu_d(cpu_d),
      .ppu_a(ppu_a),
      .prg_a(prg_a),
      .chr_a(chr_a),
      .ciram_a10(ciram_a10),
      .prg_ram_ce_n(prg_ram_ce_n),
      .reg_write(reg_write),
      .reg_index(reg_index)
   );

   always #5 master_clock = ~master_clock;

   // Every clock reg_write is high counts as one pulse, so a stretched pulse shows up.
   always @(negedge master_clock) begin
      if (reg_write === 1'b1) begin
         wr_count = wr_count + 1;
         last_idx = reg_index;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge master_clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic bus_cycle(input logic rw, input logic rs, input logic [1:0] a, input logic [1:0] d);
      cpu_rw = rw;
      romsel = rs;
      cpu_a  = a;
      cpu_d  = d;
      m2     = 1'b1;
      tick(4);
      m2     = 1'b0;
      tick(5);
      romsel = 1'b1;
      cpu_rw = 1'b1;
   endtask

   task automatic write_bit(input logic [1:0] a, input logic b);
      bus_cycle(1'b0, 1'b0, a, {1'b0, b});
   endtask

   task automatic read_cycle(input logic [1:0] a);
      bus_cycle(1'b1, 1'b0, a, 2'b00);
   endtask

   task automatic load_reg(input logic [1:0] a, input logic [4:0] val);
      for (int i = 0; i < 5; i++) begin
         write_bit(a, val[i]);
         read_cycle(a);
      end
   endtask

   initial begin
      reset  = 1'b1;
      m2     = 1'b0;
      romsel = 1'b1;
      cpu_rw = 1'b1;
      cpu_a  = 2'b00;
      cpu_d  = 2'b00;
      ppu_a  = 3'b000;

      // Reset defaults
      do_reset();
      cpu_a = 2'b10; #1;
      check_val("rst_prg_a14_1", prg_a, 4'hF);
      cpu_a = 2'b00; #1;
      check_val("rst_prg_a14_0", prg_a, 4'h0);
      ppu_a = 3'b100; #1;
      check_val("rst_chr_a12_1", chr_a, 5'd1);
      ppu_a = 3'b011; #1;
      check_val("rst_ciram", ciram_a10, 1'b0);
      check_val("rst_no_pulse", wr_count, 0);

      // PRG commit: bits 1,0,1,0,0 to $E000
      base = wr_count;
      write_bit(2'b11, 1'b1); read_cycle(2'b11);
      write_bit(2'b11, 1'b0); read_cycle(2'b11);
      write_bit(2'b11, 1'b1); read_cycle(2'b11);
      write_bit(2'b11, 1'b0); read_cycle(2'b11);
      check_val("prg_no_commit_4bits", wr_count, base);
      write_bit(2'b11, 1'b0); read_cycle(2'b11);
      check_val("prg_one_pulse", wr_count, base + 1);
      check_val("prg_index", last_idx, 2'd3);
      cpu_a = 2'b00; #1;
      check_val("prg_a_lo", prg_a, 4'd5);
      cpu_a = 2'b10; #1;
      check_val("prg_a_hi", prg_a, 4'hF);

      // D7 reset mid-sequence, then control = 00010
      write_bit(2'b00, 1'b1); read_cycle(2'b00);
      write_bit(2'b00, 1'b1); read_cycle(2'b00);
      base = wr_count;
      bus_cycle(1'b0, 1'b0, 2'b00, 2'b10); read_cycle(2'b00);
      load_reg(2'b00, 5'b00010);
      check_val("d7_one_pulse", wr_count, base + 1);
      check_val("d7_index", last_idx, 2'd0);
      ppu_a = 3'b001; #1;
      check_val("d7_ciram_a10_1", ciram_a10, 1'b1);
      ppu_a = 3'b110; #1;
      check_val("d7_ciram_a10_0", ciram_a10, 1'b0);
      cpu_a = 2'b00; #1;
      check_val("d7_prg_mode0_lo", prg_a, 4'd4);
      cpu_a = 2'b10; #1;
      check_val("d7_prg_mode0_hi", prg_a, 4'd5);

      // Back-to-back writes: second ignored, 6 write cycles give control = 10001
      base = wr_count;
      write_bit(2'b00, 1'b1);
      write_bit(2'b00, 1'b0);
      read_cycle(2'b00);
      write_bit(2'b00, 1'b0); read_cycle(2'b00);
      write_bit(2'b00, 1'b0); read_cycle(2'b00);
      write_bit(2'b00, 1'b0); read_cycle(2'b00);
      check_val("rmw_no_commit_5cyc", wr_count, base);
      write_bit(2'b00, 1'b1); read_cycle(2'b00);
      check_val("rmw_commit_6cyc", wr_count, base + 1);
      check_val("rmw_index", last_idx, 2'd0);
      ppu_a = 3'b000; #1;
      check_val("rmw_ciram_one", ciram_a10, 1'b1);

      // 4K CHR mode, chr0 = 4, chr1 = 9
      load_reg(2'b01, 5'd4);
      check_val("chr0_index", last_idx, 2'd1);
      load_reg(2'b10, 5'd9);
      check_val("chr1_index", last_idx, 2'd2);
      ppu_a = 3'b000; #1;
      check_val("chr4k_a12_0", chr_a, 5'd4);
      ppu_a = 3'b100; #1;
      check_val("chr4k_a12_1", chr_a, 5'd9);
      cpu_a = 2'b11; romsel = 1'b1; cpu_rw = 1'b1; m2 = 1'b1; #1;
      check_val("ram_ce_enabled", prg_ram_ce_n, 1'b0);
      cpu_a = 2'b10; #1;
      check_val("ram_ce_wrong_addr", prg_ram_ce_n, 1'b1);
      tick(4); m2 = 1'b0; tick(5);
      load_reg(2'b11, 5'b10101);
      check_val("prg_bit4_index", last_idx, 2'd3);
      cpu_a = 2'b11; m2 = 1'b1; #1;
      check_val("ram_ce_disabled", prg_ram_ce_n, 1'b1);
      check_val("prg_mode0_a14_1", prg_a, 4'd5);
      tick(4); m2 = 1'b0; tick(5);

      // Mid-sequence reset then fresh chr0 = 00110
      write_bit(2'b01, 1'b1); read_cycle(2'b01);
      write_bit(2'b01, 1'b1); read_cycle(2'b01);
      write_bit(2'b01, 1'b1); read_cycle(2'b01);
      do_reset();
      base = wr_count;
      write_bit(2'b01, 1'b0); read_cycle(2'b01);
      write_bit(2'b01, 1'b1); read_cycle(2'b01);
      write_bit(2'b01, 1'b1); read_cycle(2'b01);
      check_val("mid_no_early_commit", wr_count, base);
      write_bit(2'b01, 1'b0); read_cycle(2'b01);
      write_bit(2'b01, 1'b0); read_cycle(2'b01);
      check_val("mid_one_pulse", wr_count, base + 1);
      check_val("mid_index", last_idx, 2'd1);
      ppu_a = 3'b000; #1;
      check_val("mid_chr_a12_0", chr_a, 5'd6);
      ppu_a = 3'b100; #1;
      check_val("mid_chr_a12_1", chr_a, 5'd7);
      cpu_a = 2'b10; #1;
      check_val("mid_prg_reset", prg_a, 4'hF);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
